// File: rtl/axi_master_arbiter_pkg.sv
// Shared constants and state encoding for the two-master AXI4-Lite arbiter.
package axi_master_arbiter_pkg;

    localparam int unsigned NUM_M  = 2;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4
    } arb_state_e;

    // Counter width able to hold the watchdog limit; a zero limit still needs one bit.
    function automatic int unsigned wdog_width(input int unsigned limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/axi_master_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that was not served last wins.
module axi_master_arbiter_rr_arb2
    import axi_master_arbiter_pkg::*;
(
    input  logic [NUM_M-1:0] req_i,
    input  logic             last_i,
    output logic [NUM_M-1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Serialising round-robin arbiter: two AXI4-Lite masters onto one interconnect port,
// one whole read or write outstanding at a time.
module axi_master_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [2*ADDR_W-1:0]       m_awaddr_i,
    input  logic [1:0]                m_awvalid_i,
    output logic [1:0]                m_awready_o,
    input  logic [2*DATA_W-1:0]       m_wdata_i,
    input  logic [2*(DATA_W/8)-1:0]   m_wstrb_i,
    input  logic [1:0]                m_wvalid_i,
    output logic [1:0]                m_wready_o,
    output logic [3:0]                m_bresp_o,
    output logic [1:0]                m_bvalid_o,
    input  logic [1:0]                m_bready_i,
    input  logic [2*ADDR_W-1:0]       m_araddr_i,
    input  logic [1:0]                m_arvalid_i,
    output logic [1:0]                m_arready_o,
    output logic [2*DATA_W-1:0]       m_rdata_o,
    output logic [3:0]                m_rresp_o,
    output logic [1:0]                m_rvalid_o,
    input  logic [1:0]                m_rready_i,

    output logic [ADDR_W-1:0]         s_awaddr_o,
    output logic                      s_awvalid_o,
    input  logic                      s_awready_i,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [DATA_W/8-1:0]       s_wstrb_o,
    output logic                      s_wvalid_o,
    input  logic                      s_wready_i,
    input  logic [1:0]                s_bresp_i,
    input  logic                      s_bvalid_i,
    output logic                      s_bready_o,
    output logic [ADDR_W-1:0]         s_araddr_o,
    output logic                      s_arvalid_o,
    input  logic                      s_arready_i,
    input  logic [DATA_W-1:0]         s_rdata_i,
    input  logic [1:0]                s_rresp_i,
    input  logic                      s_rvalid_i,
    output logic                      s_rready_o,

    output logic [1:0]                grant_o,
    output logic                      timeout_err_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = wdog_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(TIMEOUT_CYC);

    arb_state_e          state_q, state_d;
    logic                last_q, last_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic                timeout_q, timeout_d;

    logic [1:0]          req_c;
    logic [1:0]          win_oh_c;
    logic                win_idx_c;
    logic                win_wr_c;
    logic                owner_c;

    assign req_c[0] = (m_awvalid_i[0] & m_wvalid_i[0]) | m_arvalid_i[0];
    assign req_c[1] = (m_awvalid_i[1] & m_wvalid_i[1]) | m_arvalid_i[1];

    axi_master_arbiter_rr_arb2 u_rr_arb2 (
        .req_i  (req_c),
        .last_i (last_q),
        .gnt_o  (win_oh_c)
    );

    assign win_idx_c = win_oh_c[1];
    assign win_wr_c  = m_awvalid_i[win_idx_c] & m_wvalid_i[win_idx_c];
    assign owner_c   = grant_q[1];

    // Toward the interconnect everything comes from the capture registers.
    assign s_awaddr_o    = addr_q;
    assign s_araddr_o    = addr_q;
    assign s_wdata_o     = wdata_q;
    assign s_wstrb_o     = wstrb_q;
    assign grant_o       = grant_q;
    assign timeout_err_o = timeout_q;

    // Response payloads are broadcast; only the owner's valid is raised.
    assign m_rdata_o = {2{s_rdata_i}};
    assign m_rresp_o = {2{s_rresp_i}};
    assign m_bresp_o = {2{s_bresp_i}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q    <= 1'b1;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        m_awready_o = 2'b00;
        m_wready_o  = 2'b00;
        m_arready_o = 2'b00;
        m_bvalid_o  = 2'b00;
        m_rvalid_o  = 2'b00;
        s_awvalid_o = 1'b0;
        s_wvalid_o  = 1'b0;
        s_arvalid_o = 1'b0;
        s_bready_o  = 1'b0;
        s_rready_o  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Accept is gated by reset so no master sees a handshake that is then dropped.
                if (!rst_i && (req_c != 2'b00)) begin
                    grant_d   = win_oh_c;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (win_wr_c) begin
                        m_awready_o = win_oh_c;
                        m_wready_o  = win_oh_c;
                        addr_d  = win_idx_c ? m_awaddr_i[2*ADDR_W-1:ADDR_W] : m_awaddr_i[ADDR_W-1:0];
                        wdata_d = win_idx_c ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0];
                        wstrb_d = win_idx_c ? m_wstrb_i[2*STRB_W-1:STRB_W] : m_wstrb_i[STRB_W-1:0];
                        state_d = ST_WR_ADDR;
                    end else begin
                        m_arready_o = win_oh_c;
                        addr_d  = win_idx_c ? m_araddr_i[2*ADDR_W-1:ADDR_W] : m_araddr_i[ADDR_W-1:0];
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                s_arvalid_o = 1'b1;
                if (s_arready_i) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                m_rvalid_o = grant_q & {2{s_rvalid_i}};
                s_rready_o = |(m_rready_i & grant_q);
                if (s_rvalid_i && s_rready_o) begin
                    last_d  = owner_c;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                s_awvalid_o = !aw_done_q;
                s_wvalid_o  = !w_done_q;
                aw_done_d   = aw_done_q | s_awready_i;
                w_done_d    = w_done_q | s_wready_i;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                m_bvalid_o = grant_q & {2{s_bvalid_i}};
                s_bready_o = |(m_bready_i & grant_q);
                if (s_bvalid_i && s_bready_o) begin
                    last_d  = owner_c;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog restarts on every state change and saturates at the limit.
        if (TIMEOUT_CYC != 0) begin
            if (state_d != state_q) begin
                wdog_d = '0;
            end else if (state_q != ST_IDLE && wdog_q != WDOG_MAX) begin
                wdog_d = wdog_q + CNT_W'(1);
            end
            timeout_d = timeout_q | (wdog_d == WDOG_MAX);
        end
    end

endmodule
